// File: rtl/eject_sink_pkg.sv
// Shared definitions for the eject sink: flit width, port indices and the
// merged-output beat. Imported by eject_fifo and eject_sink.
package eject_sink_pkg;

  localparam int unsigned FLIT_SIZE       = 32;
  localparam int unsigned NUM_EJECT_PORTS = 6;
  localparam int unsigned PORT_IDX_W      = 3;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  localparam port_idx_t PORT_XPOS = 3'd0;
  localparam port_idx_t PORT_YPOS = 3'd1;
  localparam port_idx_t PORT_ZPOS = 3'd2;
  localparam port_idx_t PORT_XNEG = 3'd3;
  localparam port_idx_t PORT_YNEG = 3'd4;
  localparam port_idx_t PORT_ZNEG = 3'd5;

  // One beat on the merged output stream
  typedef struct packed {
    logic [FLIT_SIZE-1:0] flit;
    port_idx_t            port;
  } out_beat_t;

  // Round-robin successor, wrapping zneg back to xpos
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == PORT_ZNEG) ? PORT_XPOS : port_idx_t'(p + 3'd1);
  endfunction

  // Number of set bits in a per-port flag vector (0..6)
  function automatic logic [2:0] count_ports(input logic [NUM_EJECT_PORTS-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_EJECT_PORTS; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/eject_fifo.sv
// Single-clock FIFO for one ejection port. A write while full is accepted
// when the same cycle pops, since a slot frees at that edge.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_wr_en        write request (dropped if full and not popping)
//   i_wr_data      write data
//   i_rd_en        pop request (ignored when empty)
//   o_head_c       current head entry (combinational)
//   o_full_c       FIFO holds DEPTH entries (combinational)
//   o_empty_c      FIFO holds no entries (combinational)
module eject_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_head_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];

  assign w_rd = i_rd_en && !o_empty_c;
  assign w_wr = i_wr_en && (!o_full_c || w_rd);

  // Storage carries no reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (w_wr && !rst) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/eject_sink.sv
// Node-side receiver for the six router ejection streams. Each stream lands in
// its own FIFO (no backpressure upstream); a round-robin arbiter merges them
// into one registered valid/ready stream tagged with the source port.
// Optional macro EJECT_SINK_STATS_EN enables the saturating drop_count.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   eject_<dir>, _valid      ejected flit and qualifier per direction
//   out_flit, out_port       merged flit and its source index (xpos=0..zneg=5)
//   out_valid, out_ready     output handshake
//   overflow                 sticky per-port drop flags
//   rx_count                 flits delivered on the output (wraps)
//   drop_count               total dropped flits (0 unless stats enabled)
module eject_sink
  import eject_sink_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_SIZE-1:0]       eject_xpos,
  input  logic [FLIT_SIZE-1:0]       eject_ypos,
  input  logic [FLIT_SIZE-1:0]       eject_zpos,
  input  logic [FLIT_SIZE-1:0]       eject_xneg,
  input  logic [FLIT_SIZE-1:0]       eject_yneg,
  input  logic [FLIT_SIZE-1:0]       eject_zneg,
  input  logic                       eject_xpos_valid,
  input  logic                       eject_ypos_valid,
  input  logic                       eject_zpos_valid,
  input  logic                       eject_xneg_valid,
  input  logic                       eject_yneg_valid,
  input  logic                       eject_zneg_valid,
  output logic [FLIT_SIZE-1:0]       out_flit,
  output logic [PORT_IDX_W-1:0]      out_port,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_EJECT_PORTS-1:0] overflow,
  output logic [CNT_W-1:0]           rx_count,
  output logic [15:0]                drop_count
);

  logic [FLIT_SIZE-1:0]       w_eject_flit [NUM_EJECT_PORTS];
  logic [NUM_EJECT_PORTS-1:0] w_eject_valid;
  logic [FLIT_SIZE-1:0]       w_head       [NUM_EJECT_PORTS];
  logic [NUM_EJECT_PORTS-1:0] w_full;
  logic [NUM_EJECT_PORTS-1:0] w_empty;
  logic [NUM_EJECT_PORTS-1:0] w_pop;
  logic [NUM_EJECT_PORTS-1:0] w_drop;
  logic                       w_load;
  logic                       w_take;
  logic                       w_grant_found;
  port_idx_t                  w_grant_idx;

  out_beat_t                  r_out;
  logic                       r_out_valid;
  port_idx_t                  r_rr_ptr;
  logic [NUM_EJECT_PORTS-1:0] r_overflow;
  logic [CNT_W-1:0]           r_rx_count;

  assign w_eject_flit[PORT_XPOS] = eject_xpos;
  assign w_eject_flit[PORT_YPOS] = eject_ypos;
  assign w_eject_flit[PORT_ZPOS] = eject_zpos;
  assign w_eject_flit[PORT_XNEG] = eject_xneg;
  assign w_eject_flit[PORT_YNEG] = eject_yneg;
  assign w_eject_flit[PORT_ZNEG] = eject_zneg;

  assign w_eject_valid = {eject_zneg_valid, eject_yneg_valid, eject_xneg_valid,
                          eject_zpos_valid, eject_ypos_valid, eject_xpos_valid};

  for (genvar i = 0; i < NUM_EJECT_PORTS; i++) begin : g_fifo
    eject_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(FLIT_SIZE)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_wr_en  (w_eject_valid[i]),
      .i_wr_data(w_eject_flit[i]),
      .i_rd_en  (w_pop[i]),
      .o_head_c (w_head[i]),
      .o_full_c (w_full[i]),
      .o_empty_c(w_empty[i])
    );

    assign w_pop[i] = w_take && (w_grant_idx == port_idx_t'(i));
  end

  // A flit is lost only when its FIFO is full and not freeing a slot this cycle
  assign w_drop = w_eject_valid & w_full & ~w_pop;

  // Output register may load when empty or when its current beat is taken
  assign w_load = !r_out_valid || out_ready;
  assign w_take = w_load && w_grant_found;

  // Round-robin scan starting just after the last granted port
  always_comb begin
    port_idx_t scan;
    w_grant_found = 1'b0;
    w_grant_idx   = r_rr_ptr;
    scan          = r_rr_ptr;
    for (int k = 0; k < NUM_EJECT_PORTS; k++) begin
      scan = next_port(scan);
      if (!w_grant_found && !w_empty[scan]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = scan;
      end
    end
  end

  // Output register, arbiter pointer and status counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= PORT_ZNEG;
      r_overflow  <= '0;
      r_rx_count  <= '0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_rx_count <= r_rx_count + 1'b1;
      end
      if (w_load) begin
        r_out_valid <= w_grant_found;
        if (w_grant_found) begin
          r_out.flit <= w_head[w_grant_idx];
          r_out.port <= w_grant_idx;
          r_rr_ptr   <= w_grant_idx;
        end
      end
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign out_flit  = r_out.flit;
  assign out_port  = r_out.port;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
  assign rx_count  = r_rx_count;

`ifdef EJECT_SINK_STATS_EN
  logic [15:0] r_drop_count;
  logic [16:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_drop_count} + 17'(count_ports(w_drop));

  // Saturating total of dropped flits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
    end else begin
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'd0;
`endif

endmodule
